// File: rtl/ecg_window_buffer.sv
// ECG window buffer: packs a stream of gained, saturated samples into
// IN_SIZE-sample windows for the encoder, with batch tracking.
module ecg_window_buffer #(
  parameter int BITSIZE    = 16,
  parameter int IN_SIZE    = 92,
  parameter int BATCH      = 32,
  parameter int GAIN_SHIFT = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [BITSIZE-1:0]         s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [BITSIZE*IN_SIZE-1:0] x,
  output logic                       x_valid,
  input  logic                       x_ready,
  output logic [$clog2(BATCH)-1:0]   win_idx,
  output logic                       sat_flag,
  output logic                       batch_done
);

  localparam int CW = $clog2(IN_SIZE);
  localparam int WW = $clog2(BATCH);
  localparam int W  = BITSIZE + GAIN_SHIFT;

  localparam logic signed [W-1:0] MAXV =
    W'((64'sd1 <<< (BITSIZE-1)) - 64'sd1);
  localparam logic signed [W-1:0] MINV =
    W'(-(64'sd1 <<< (BITSIZE-1)));
  localparam logic [BITSIZE-1:0] SMAX =
    {1'b0, {(BITSIZE-1){1'b1}}};
  localparam logic [BITSIZE-1:0] SMIN =
    {1'b1, {(BITSIZE-1){1'b0}}};

  typedef enum logic {FILL, FULL} state_t;

  state_t                     state_q;
  logic [CW-1:0]              cnt_q;
  logic [BITSIZE*IN_SIZE-1:0] x_q;
  logic [WW-1:0]              win_q;
  logic                       sat_q;
  logic                       bd_q;

  logic signed [W-1:0] wide;
  logic                ovf;
  logic [BITSIZE-1:0]  samp_d;
  logic                accept;
  logic                handoff;
  logic                last_slot;
  logic                last_win;

  // Gain is applied at extended width so overflow is visible before clamping
  always_comb begin
    wide   = W'($signed(s_data)) <<< GAIN_SHIFT;
    ovf    = (wide > MAXV) || (wide < MINV);
    samp_d = wide[BITSIZE-1:0];
    if (ovf) samp_d = wide[W-1] ? SMIN : SMAX;
  end

  assign accept    = (state_q == FILL) && s_valid;
  assign handoff   = (state_q == FULL) && x_ready;
  assign last_slot = (cnt_q == CW'(IN_SIZE-1));
  assign last_win  = (win_q == WW'(BATCH-1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
      x_q     <= '0;
      win_q   <= '0;
      sat_q   <= 1'b0;
      bd_q    <= 1'b0;
    end else begin
      bd_q <= 1'b0;
      if (accept) begin
        x_q[cnt_q*BITSIZE +: BITSIZE] <= samp_d;
        if (ovf) sat_q <= 1'b1;
        if (last_slot) begin
          state_q <= FULL;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      if (handoff) begin
        state_q <= FILL;
        cnt_q   <= '0;
        sat_q   <= 1'b0;
        if (last_win) begin
          win_q <= '0;
          bd_q  <= 1'b1;
        end else begin
          win_q <= win_q + 1'b1;
        end
      end
    end
  end

  assign s_ready    = (state_q == FILL);
  assign x_valid    = (state_q == FULL);
  assign x          = x_q;
  assign win_idx    = win_q;
  assign sat_flag   = sat_q;
  assign batch_done = bd_q;

endmodule

// File: tb/tb_ecg_window_buffer.sv
// Directed and randomized checks of ecg_window_buffer against
// hand-computed windows (gain 0 and gain 2 instances share stimulus).
module tb_ecg_window_buffer;

  localparam int BS = 16;
  localparam int N  = 92;
  localparam int B  = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [BS-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          x_ready = 1'b0;

  logic          s_ready0, x_valid0, sat0, bd0;
  logic [N*BS-1:0] x0;
  logic [4:0]    win0;
  logic          s_ready2, x_valid2, sat2, bd2;
  logic [N*BS-1:0] x2;
  logic [4:0]    win2;

  int errs = 0;
  int checks = 0;

  logic [BS-1:0] rdata [0:5*N-1];
  int sent, wn, cyc, wbad, bdcnt, bdbad;
  bit checked;

  ecg_window_buffer #(.BITSIZE(BS), .IN_SIZE(N), .BATCH(B),
                      .GAIN_SHIFT(0)) u_dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready0), .x(x0), .x_valid(x_valid0), .x_ready(x_ready),
    .win_idx(win0), .sat_flag(sat0), .batch_done(bd0)
  );

  ecg_window_buffer #(.BITSIZE(BS), .IN_SIZE(N), .BATCH(B),
                      .GAIN_SHIFT(2)) u_dut_g2 (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready2), .x(x2), .x_valid(x_valid2), .x_ready(x_ready),
    .win_idx(win2), .sat_flag(sat2), .batch_done(bd2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BS-1:0] slot0(input int k);
    return x0[k*BS +: BS];
  endfunction

  function automatic logic [BS-1:0] slot2(input int k);
    return x2[k*BS +: BS];
  endfunction

  function automatic int bad_const(input logic [BS-1:0] v);
    int n;
    n = 0;
    for (int k = 0; k < N; k++) if (slot0(k) !== v) n++;
    return n;
  endfunction

  function automatic int bad_ramp(input int off);
    int n;
    n = 0;
    for (int k = 0; k < N; k++)
      if (slot0(k) !== BS'(off + k)) n++;
    return n;
  endfunction

  function automatic int bad_rand(input int base);
    int n;
    n = 0;
    for (int k = 0; k < N; k++)
      if (slot0(k) !== rdata[base + k]) n++;
    return n;
  endfunction

  task automatic do_reset();
    reset   = 1'b0;
    s_valid = 1'b0;
    x_ready = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic push(input logic [BS-1:0] d);
    s_data  = d;
    s_valid = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // reset state
    tick();
    do_reset();
    chk("rst_s_ready", s_ready0, 1);
    chk("rst_x_valid", x_valid0, 0);
    chk("rst_win_idx", win0, 0);
    chk("rst_sat", sat0, 0);
    chk("rst_batch_done", bd0, 0);
    chk("rst_x_zero", bad_const(16'h0000), 0);

    // constant 1.0 window
    for (int k = 0; k < N - 1; k++) push(16'd2048);
    chk("fill_no_early_valid", x_valid0, 0);
    push(16'd2048);
    s_valid = 1'b0;
    chk("full_x_valid", x_valid0, 1);
    chk("full_s_ready", s_ready0, 0);
    chk("full_slots_2048", bad_const(16'd2048), 0);
    chk("full_sat", sat0, 0);

    // ramp window, s_valid held high while FULL
    do_reset();
    for (int k = 0; k < N; k++) push(BS'(k));
    s_data = 16'd92;
    for (int i = 0; i < 5; i++) tick();
    chk("hold_x_valid", x_valid0, 1);
    chk("hold_ramp", bad_ramp(0), 0);
    chk("hold_win_idx", win0, 0);
    x_ready = 1'b1;
    tick();
    x_ready = 1'b0;
    chk("handoff_x_valid", x_valid0, 0);
    chk("handoff_win_idx", win0, 1);
    chk("handoff_slot0_kept", slot0(0), 0);
    tick();
    chk("next_slot0", slot0(0), 92);
    chk("next_slot1_kept", slot0(1), 1);
    s_data = 16'd93;
    tick();
    s_valid = 1'b0;
    chk("next_slot1", slot0(1), 93);
    chk("next_slot2_kept", slot0(2), 2);

    // gain and saturation
    do_reset();
    push(16'hE000);
    push(16'h1FFF);
    chk("g2_edge_slot0", slot2(0), 16'h8000);
    chk("g2_edge_slot1", slot2(1), 16'h7FFC);
    chk("g2_no_sat", sat2, 0);
    push(16'h2000);
    push(16'hDFFF);
    chk("g2_pos_clamp", slot2(2), 16'h7FFF);
    chk("g2_neg_clamp", slot2(3), 16'h8000);
    chk("g2_sat", sat2, 1);
    chk("g0_slot2", slot0(2), 16'h2000);
    chk("g0_slot3", slot0(3), 16'hDFFF);
    chk("g0_no_sat", sat0, 0);
    for (int k = 4; k < N; k++) push(16'h0000);
    s_valid = 1'b0;
    chk("g2_full", x_valid2, 1);
    chk("g2_sat_held", sat2, 1);
    x_ready = 1'b1;
    tick();
    x_ready = 1'b0;
    chk("g2_sat_cleared", sat2, 0);
    chk("g2_win_idx", win2, 1);

    // full batch with x_ready tied high
    do_reset();
    x_ready = 1'b1;
    wbad = 0;
    bdcnt = 0;
    bdbad = 0;
    for (int w = 0; w < B; w++) begin
      if (win0 !== 5'(w)) wbad++;
      for (int k = 0; k < N; k++) push(BS'(w + k));
      s_valid = 1'b0;
      tick();
      if (bd0) bdcnt++;
      if (bd0 && w != B - 1) bdbad++;
    end
    chk("batch_done_pulse", bd0, 1);
    chk("batch_win_seq", wbad, 0);
    chk("batch_done_count", bdcnt, 1);
    chk("batch_done_early", bdbad, 0);
    chk("batch_wrap", win0, 0);
    tick();
    chk("batch_done_one_cycle", bd0, 0);
    x_ready = 1'b0;

    // reset mid-fill, with reset winning over s_valid
    do_reset();
    for (int k = 0; k < 50; k++) push(16'd7);
    s_data  = 16'd9;
    s_valid = 1'b1;
    reset   = 1'b0;
    tick();
    reset   = 1'b1;
    s_valid = 1'b0;
    chk("midrst_x_zero", bad_const(16'h0000), 0);
    chk("midrst_x_valid", x_valid0, 0);
    chk("midrst_s_ready", s_ready0, 1);
    for (int k = 0; k < N; k++) push(BS'(100 + k));
    s_valid = 1'b0;
    chk("midrst_full", x_valid0, 1);
    chk("midrst_ramp", bad_ramp(100), 0);
    chk("midrst_win_idx", win0, 0);
    chk("midrst_no_bd", bd0, 0);

    // random gaps on both sides
    for (int i = 0; i < 5*N; i++) rdata[i] = BS'($urandom);
    do_reset();
    sent = 0;
    wn = 0;
    cyc = 0;
    checked = 1'b0;
    while (wn < 4 && cyc < 6000) begin
      if (x_valid0 && !checked) begin
        chk($sformatf("rand_win%0d", wn), bad_rand(wn*N), 0);
        chk($sformatf("rand_idx%0d", wn), win0, wn);
        checked = 1'b1;
      end
      s_valid = (sent < 4*N) && ($urandom_range(0, 2) != 0);
      s_data  = rdata[sent];
      x_ready = 1'($urandom_range(0, 1));
      if (s_valid && s_ready0) sent++;
      if (x_ready && x_valid0) begin
        wn++;
        checked = 1'b0;
      end
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    x_ready = 1'b0;
    chk("rand_windows_done", wn, 4);
    chk("rand_samples_sent", sent, 4*N);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ecg_window_buffer.md
ECG_WINDOW_BUFFER -- requirements
Module: ecg_window_buffer

Interface
REQ-001 Parameter BITSIZE, default 16, sample width, Q4.11 signed fixed-point.
REQ-002 Parameter IN_SIZE, default 92, samples per window (encoder input vector length).
REQ-003 Parameter BATCH, default 32, windows per batch.
REQ-004 Parameter GAIN_SHIFT, default 0, range 0..4, arithmetic left-shift gain applied to each sample.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 reset  input  1  synchronous, active-low; reset==0 at a rising edge resets the block.
REQ-007 s_data  input  BITSIZE  signed incoming ECG sample.
REQ-008 s_valid  input  1  s_data valid.
REQ-009 s_ready  output  1  block accepts a sample this cycle.
REQ-010 x  output  BITSIZE*IN_SIZE  assembled window; sample k at x[k*BITSIZE +: BITSIZE].
REQ-011 x_valid  output  1  x holds a complete window.
REQ-012 x_ready  input  1  downstream encoder accepts x.
REQ-013 win_idx  output  $clog2(BATCH)  index of the window currently being filled or presented.
REQ-014 sat_flag  output  1  at least one sample in the current window saturated.
REQ-015 batch_done  output  1  one-cycle pulse after the BATCH-th window handoff.

Function
REQ-016 Two states: FILL (s_ready=1, x_valid=0) and FULL (s_ready=0, x_valid=1).
REQ-017 Sample accepted on a rising edge with state FILL and s_valid=1; written into slot cnt, cnt increments.
REQ-018 Sample k of a window goes to slot k; first accepted sample is slot 0.
REQ-019 Stored value = s_data <<< GAIN_SHIFT, computed at BITSIZE+GAIN_SHIFT bits, clamped to [-32768, 32767] for BITSIZE=16.
REQ-020 Any clamp sets sat_flag; sat_flag stays set until the window handoff.
REQ-021 Acceptance of slot IN_SIZE-1 moves FILL->FULL on the same edge; x_valid=1 and s_ready=0 from the next cycle (zero-bubble latency, one edge).
REQ-022 In FULL, x, win_idx and sat_flag are held stable; s_valid is ignored and no sample is consumed.
REQ-023 Handoff: rising edge with FULL and x_ready=1 -> FILL, cnt=0, sat_flag=0, win_idx increments.
REQ-024 x_ready in FILL is ignored.
REQ-025 Handoff with win_idx=BATCH-1 wraps win_idx to 0 and sets batch_done=1 for exactly the next cycle.
REQ-026 x contents are not cleared at handoff; slots are overwritten as the new window fills.
REQ-027 No sample is dropped or duplicated: every s_valid&&s_ready edge consumes exactly one sample.

Reset
REQ-028 reset==0 at a rising edge: state FILL, cnt=0, win_idx=0, x=0, x_valid=0, sat_flag=0, batch_done=0; s_ready=1 from the next cycle.
REQ-029 Reset mid-fill or in FULL discards the partial/held window; no handoff or batch_done is generated.
REQ-030 Reset has priority over any simultaneous s_valid or x_ready.

Verification
REQ-031 Stream 92 samples of 2048 (1.0), GAIN_SHIFT=0, x_ready=0 -> x_valid=1 one cycle after the 92nd, all slots 2048, s_ready=0, sat_flag=0.
REQ-032 Samples 0..91 with value k, then s_valid held high 5 extra cycles in FULL -> slot k == k, no extra sample consumed; after x_ready pulse the next window starts with sample 92.
REQ-033 GAIN_SHIFT=2, samples 8192 and -8193 -> stored 32767 and -32768, sat_flag=1; cleared after handoff.
REQ-034 32 full windows with x_ready=1 -> win_idx 0..31, batch_done single pulse after the 32nd handoff, win_idx=0.
REQ-035 reset=0 after 50 samples accepted -> cnt=0, x=0, no x_valid; the next 92 samples form window 0.
REQ-036 Random s_valid/x_ready gaps vs. reference model -> every window bit-exact, no loss or duplication.
